// File: rtl/pixel_pkg.sv
// Shared types and the luma helper for the pixel edge finder.
package pixel_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Weighted luma (R + 2G + B) / 4; the 10-bit sum cannot overflow (max 1020).
    function automatic logic [7:0] luma(input pixel_t p);
        logic [9:0] sum;
        sum = {2'b00, p.red} + {1'b0, p.green, 1'b0} + {2'b00, p.blue};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/median3.sv
// Combinational 3-input median of unsigned 8-bit values.
module median3 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_c,
    output logic [7:0] o_med
);

    logic [7:0] w_lo;
    logic [7:0] w_hi;
    logic [7:0] w_hi_c;

    // median = max(min(a,b), min(max(a,b), c))
    always_comb begin
        w_lo   = (i_a < i_b) ? i_a : i_b;
        w_hi   = (i_a < i_b) ? i_b : i_a;
        w_hi_c = (w_hi < i_c) ? w_hi : i_c;
        o_med  = (w_lo > w_hi_c) ? w_lo : w_hi_c;
    end

endmodule

// File: rtl/pixel_edge_finder.sv
// Line-based edge finder: luma -> 3-tap median -> gradient magnitude -> threshold.
// Column k is reported one cycle after pixel k+1 is accepted (or after the
// line's last pixel moves the FSM into FLUSH).
module pixel_edge_finder
    import pixel_pkg::*;
#(
    parameter int INDEX_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  pixel_t                 in_pixel,
    input  logic                   in_last,
    input  logic [7:0]             threshold,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [7:0]             out_magnitude,
    output logic                   out_edge,
    output logic                   out_last,
    output logic [INDEX_WIDTH-1:0] edge_count
);

    localparam logic [INDEX_WIDTH-1:0] IDX_ONE = 1;

    // |a - b| for unsigned 8-bit operands, via a signed 9-bit difference.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        logic signed [8:0] n;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        n = -d;
        return d[8] ? n[7:0] : d[7:0];
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_slot_free;
    logic                   w_accept;
    logic                   w_emit;

    logic [7:0]             r_luma_prev;
    logic [7:0]             r_luma_cur;
    logic [7:0]             r_med_prev;
    logic                   r_first;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [7:0]             r_thr;
    logic [INDEX_WIDTH-1:0] r_cnt;

    logic [7:0]             w_luma_p0;
    logic [7:0]             w_right_p0;
    logic [7:0]             w_med_p0;
    logic [7:0]             w_mag_p0;
    logic                   w_edge_p0;

    assign w_slot_free = !out_valid || out_ready;
    assign in_ready    = (r_state != FLUSH) && w_slot_free;
    assign w_accept    = in_valid && in_ready;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and output-load decision.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = in_last ? FLUSH : RUN;
            end
            RUN: begin
                if (w_accept) begin
                    w_emit = 1'b1;
                    if (in_last) w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (w_slot_free) begin
                    w_emit      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stage p0: luma of the incoming pixel, median and gradient for the pending column.
    // In FLUSH the right neighbour is the last pixel itself (line-end replication).
    assign w_luma_p0  = luma(in_pixel);
    assign w_right_p0 = (r_state == FLUSH) ? r_luma_cur : w_luma_p0;

    median3 u_median3 (
        .i_a   (r_luma_prev),
        .i_b   (r_luma_cur),
        .i_c   (w_right_p0),
        .o_med (w_med_p0)
    );

    assign w_mag_p0  = r_first ? 8'd0 : abs_diff(w_med_p0, r_med_prev);
    assign w_edge_p0 = (w_mag_p0 >= r_thr);

    // Luma window and previous median; the first pixel fills both taps (left replication).
    always_ff @(posedge clock) begin
        if (r_state == IDLE && w_accept) begin
            r_luma_prev <= w_luma_p0;
            r_luma_cur  <= w_luma_p0;
        end else if (r_state == RUN && w_accept) begin
            r_luma_prev <= r_luma_cur;
            r_luma_cur  <= w_luma_p0;
            r_med_prev  <= w_med_p0;
        end
    end

    // Per-line control: column counter, first-column flag, latched threshold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx   <= '0;
            r_first <= 1'b1;
            r_thr   <= 8'd0;
        end else if (r_state == IDLE && w_accept) begin
            r_idx   <= '0;
            r_first <= 1'b1;
            r_thr   <= threshold;
        end else if (r_state == RUN && w_accept) begin
            r_idx   <= r_idx + IDX_ONE;
            r_first <= 1'b0;
        end
    end

    // Stage p1: output register, held until the downstream transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_index     <= '0;
            out_magnitude <= 8'd0;
            out_edge      <= 1'b0;
            out_last      <= 1'b0;
        end else if (w_emit) begin
            out_valid     <= 1'b1;
            out_index     <= r_idx;
            out_magnitude <= w_mag_p0;
            out_edge      <= w_edge_p0;
            out_last      <= (r_state == FLUSH);
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // Edge tally counted on transfers; published when the end-of-line column leaves.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            edge_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                edge_count <= r_cnt + {{(INDEX_WIDTH-1){1'b0}}, out_edge};
                r_cnt      <= '0;
            end else begin
                r_cnt      <= r_cnt + {{(INDEX_WIDTH-1){1'b0}}, out_edge};
            end
        end
    end

endmodule

// File: tb/tb_pixel_edge_finder.sv
// Directed testbench for pixel_edge_finder.
module tb_pixel_edge_finder;
    import pixel_pkg::*;

    localparam int IW = 12;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    pixel_t        in_pixel;
    logic          in_last;
    logic [7:0]    threshold;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [7:0]    out_magnitude;
    logic          out_edge;
    logic          out_last;
    logic [IW-1:0] edge_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [7:0]    mag;
        logic          edg;
        logic          last;
    } cap_t;

    cap_t   cap_q[$];
    pixel_t line_px [0:15];

    pixel_edge_finder #(.INDEX_WIDTH(IW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .in_last       (in_last),
        .threshold     (threshold),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_index     (out_index),
        .out_magnitude (out_magnitude),
        .out_edge      (out_edge),
        .out_last      (out_last),
        .edge_count    (edge_count)
    );

    always #5 clock = ~clock;

    // Record every output transfer (sampled half a cycle before the edge that completes it).
    always @(negedge clock) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            cap_q.push_back({out_index, out_magnitude, out_edge, out_last});
    end

    task automatic set_gray(input int n, input logic [7:0] g [0:15]);
        for (int i = 0; i < n; i++) line_px[i] = '{red: g[i], green: g[i], blue: g[i]};
    endtask

    // Offer n pixels; threshold is valid only on the first one, junk afterwards.
    task automatic send_line(input int n, input logic [7:0] thr, input bit mark_last);
        for (int i = 0; i < n; i++) begin
            int t;
            in_valid  = 1'b1;
            in_pixel  = line_px[i];
            in_last   = mark_last && (i == n - 1);
            threshold = (i == 0) ? thr : 8'hFF;
            t = 0;
            @(negedge clock);
            while (in_ready !== 1'b1 && t < 100) begin
                t++;
                @(negedge clock);
            end
            if (t >= 100) begin
                checks++; errors++;
                $display("FAIL send_timeout pixel=%0d in_ready=%b required=1", i, in_ready);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait until the end-of-line column has transferred; returns one cycle after it.
    task automatic wait_last();
        int t;
        t = 0;
        while (!(cap_q.size() > 0 && cap_q[cap_q.size()-1].last) && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL wait_last timeout captured=%0d required_last=1", cap_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_pixel = '0;
        threshold = 8'd0; out_ready = 1'b1;
        repeat (2) @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if ({out_index, out_magnitude, out_edge, out_last} !== '0) begin
            errors++; $display("FAIL reset_fields got=%h/%h/%b/%b exp=0", out_index, out_magnitude, out_edge, out_last);
        end
        checks++;
        if (edge_count !== '0) begin errors++; $display("FAIL reset_edge_count got=%0d exp=0", edge_count); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_flat();
        logic [7:0] g [0:15];
        logic [7:0] exp_mag [0:3];
        exp_mag = '{0, 0, 0, 0};
        for (int i = 0; i < 16; i++) g[i] = 8'd100;
        set_gray(4, g);
        cap_q.delete();
        send_line(4, 8'd10, 1'b1);
        wait_last();
        checks++;
        if (cap_q.size() !== 4) begin errors++; $display("FAIL flat_count got=%0d exp=4", cap_q.size()); end
        for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
            cap_t e;
            e = {IW'(i), exp_mag[i], 1'b0, (i == 3)};
            checks++;
            if (cap_q[i] !== e) begin errors++; $display("FAIL flat_out[%0d] got=%h exp=%h", i, cap_q[i], e); end
        end
        checks++;
        if (edge_count !== 12'd0) begin errors++; $display("FAIL flat_edge_count got=%0d exp=0", edge_count); end
    endtask

    task automatic test_step();
        logic [7:0] g [0:15];
        logic [7:0] exp_mag [0:5];
        exp_mag = '{0, 0, 0, 200, 0, 0};
        for (int i = 0; i < 16; i++) g[i] = (i < 3) ? 8'd0 : 8'd200;
        set_gray(6, g);
        cap_q.delete();
        send_line(6, 8'd50, 1'b1);
        wait_last();
        checks++;
        if (cap_q.size() !== 6) begin errors++; $display("FAIL step_count got=%0d exp=6", cap_q.size()); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            cap_t e;
            e = {IW'(i), exp_mag[i], (i == 3), (i == 5)};
            checks++;
            if (cap_q[i] !== e) begin errors++; $display("FAIL step_out[%0d] got=%h exp=%h", i, cap_q[i], e); end
        end
        checks++;
        if (edge_count !== 12'd1) begin errors++; $display("FAIL step_edge_count got=%0d exp=1", edge_count); end
    endtask

    task automatic test_impulse();
        logic [7:0] g [0:15];
        for (int i = 0; i < 16; i++) g[i] = (i == 2) ? 8'd255 : 8'd0;
        set_gray(5, g);
        cap_q.delete();
        send_line(5, 8'd10, 1'b1);
        wait_last();
        checks++;
        if (cap_q.size() !== 5) begin errors++; $display("FAIL impulse_count got=%0d exp=5", cap_q.size()); end
        for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
            cap_t e;
            e = {IW'(i), 8'd0, 1'b0, (i == 4)};
            checks++;
            if (cap_q[i] !== e) begin errors++; $display("FAIL impulse_out[%0d] got=%h exp=%h", i, cap_q[i], e); end
        end
        checks++;
        if (edge_count !== 12'd0) begin errors++; $display("FAIL impulse_edge_count got=%0d exp=0", edge_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] g [0:15];
        logic [7:0] exp_mag [0:5];
        exp_mag = '{0, 0, 0, 200, 0, 0};
        for (int i = 0; i < 16; i++) g[i] = (i < 3) ? 8'd0 : 8'd200;
        set_gray(6, g);
        cap_q.delete();
        fork
            send_line(6, 8'd50, 1'b1);
            begin
                logic [IW+10:0] snap;
                logic [IW+10:0] cur;
                snap = '0;
                repeat (3) @(posedge clock);
                #2 out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clock);
                    cur = {out_valid, out_index, out_magnitude, out_edge, out_last};
                    if (c == 0) begin
                        snap = cur;
                        checks++;
                        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
                    end
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", c, in_ready); end
                    checks++;
                    if (cur !== snap) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", c, cur, snap); end
                end
                @(posedge clock); #2 out_ready = 1'b1;
            end
        join
        wait_last();
        checks++;
        if (cap_q.size() !== 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", cap_q.size()); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            cap_t e;
            e = {IW'(i), exp_mag[i], (i == 3), (i == 5)};
            checks++;
            if (cap_q[i] !== e) begin errors++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, cap_q[i], e); end
        end
        checks++;
        if (edge_count !== 12'd1) begin errors++; $display("FAIL bp_edge_count got=%0d exp=1", edge_count); end
    endtask

    task automatic test_reset_midline();
        logic [7:0] g [0:15];
        logic [7:0] exp_mag [0:5];
        exp_mag = '{0, 0, 0, 200, 0, 0};
        for (int i = 0; i < 16; i++) g[i] = (i < 3) ? 8'd0 : 8'd200;
        set_gray(6, g);
        cap_q.delete();
        send_line(3, 8'd50, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midline_valid_before got=%b exp=1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midline_reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (edge_count !== 12'd0) begin errors++; $display("FAIL midline_reset_edge_count got=%0d exp=0", edge_count); end
        checks++;
        if (out_index !== 12'd0) begin errors++; $display("FAIL midline_reset_index got=%0d exp=0", out_index); end
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        cap_q.delete();
        send_line(6, 8'd50, 1'b1);
        wait_last();
        checks++;
        if (cap_q.size() !== 6) begin errors++; $display("FAIL after_reset_count got=%0d exp=6", cap_q.size()); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            cap_t e;
            e = {IW'(i), exp_mag[i], (i == 3), (i == 5)};
            checks++;
            if (cap_q[i] !== e) begin errors++; $display("FAIL after_reset_out[%0d] got=%h exp=%h", i, cap_q[i], e); end
        end
        checks++;
        if (edge_count !== 12'd1) begin errors++; $display("FAIL after_reset_edge_count got=%0d exp=1", edge_count); end
    endtask

    task automatic test_single();
        cap_t e;
        line_px[0] = '{red: 8'd10, green: 8'd20, blue: 8'd30};
        cap_q.delete();
        send_line(1, 8'd5, 1'b1);
        // Straight to FLUSH: input is refused even though the output slot is empty.
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL single_no_run in_ready got=%b exp=0", in_ready); end
        wait_last();
        checks++;
        if (cap_q.size() !== 1) begin errors++; $display("FAIL single_count got=%0d exp=1", cap_q.size()); end
        e = {IW'(0), 8'd0, 1'b0, 1'b1};
        if (cap_q.size() > 0) begin
            checks++;
            if (cap_q[0] !== e) begin errors++; $display("FAIL single_out got=%h exp=%h", cap_q[0], e); end
        end
        checks++;
        if (edge_count !== 12'd0) begin errors++; $display("FAIL single_edge_count got=%0d exp=0", edge_count); end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_step();
        test_impulse();
        test_backpressure();
        test_reset_midline();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t limit=500000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/pixel_edge_finder.md
PIXEL_EDGE_FINDER -- requirements
Module: pixel_edge_finder

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 12, giving the column index and edge count width.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  an input pixel is offered.
REQ-005 SHALL have port in_ready  output  1  an input pixel is accepted when in_valid && in_ready.
REQ-006 SHALL have port in_pixel  input  24  a pixel_t with red, green and blue, each 8 bits unsigned.
REQ-007 SHALL have port in_last  input  1  marks the final pixel of a line.
REQ-008 SHALL have port threshold  input  8  edge threshold, sampled when the first pixel of a line is accepted.
REQ-009 SHALL have port out_valid, out_ready  output/input  1  output handshake; a transfer occurs when both are high.
REQ-010 SHALL have port out_index  output  INDEX_WIDTH  column of the reported pixel.
REQ-011 SHALL have port out_magnitude  output  8  gradient magnitude.
REQ-012 SHALL have port out_edge, out_last  output  1  edge flag and end-of-line flag.
REQ-013 SHALL have port edge_count  output  INDEX_WIDTH  count of edges in the most recently completed line.

Function
REQ-014 SHALL compute luma = (red + 2*green + blue) >> 2, with a 10-bit intermediate and an 8-bit result.
REQ-015 SHALL compute median[k] as the 3-tap median of luma[k-1], luma[k] and luma[k+1], replicating the line-end pixels at k=0 and k=N-1.
REQ-016 SHALL compute out_magnitude[k] = |median[k] - median[k-1]|, and SHALL output 0 for k=0.
REQ-017 SHALL assert out_edge when out_magnitude >= the threshold latched for the line.
REQ-018 SHALL implement the states IDLE (no pixel held), RUN (at least one pixel of the line held) and FLUSH (emitting the final column).
REQ-019 SHALL make the following transitions from IDLE: an accepted pixel without in_last goes to RUN with no output; an accepted pixel with in_last goes to FLUSH.
REQ-020 SHALL make the following transitions from RUN: an accepted pixel k+1 registers the output for column k on the next cycle; if that pixel carries in_last, the state goes to FLUSH.
REQ-021 SHALL, in FLUSH, register the output for column N-1 with out_last=1 and then return to IDLE.
REQ-022 SHALL drive in_ready = (state != FLUSH) && (!out_valid || out_ready).
REQ-023 SHALL hold out_valid and all out_* fields stable until the transfer occurs.
REQ-024 SHALL have a latency of one cycle from acceptance of pixel k+1 (or entry into FLUSH) to out_valid for column k.
REQ-025 SHALL wrap the column index modulo 2^INDEX_WIDTH, and SHALL restart the index at 0 on each new line.
REQ-026 SHALL update edge_count on the out_last transfer, including that final pixel's edge, and SHALL hold it otherwise.
REQ-027 SHALL treat an out_ready/in_valid coincidence during backpressure as follows: no pixel is dropped and no output is duplicated.

Reset
REQ-028 SHALL, while reset_n is low, force state=IDLE and out_valid=0, and SHALL set out_index, out_magnitude, out_edge, out_last, edge_count and the latched threshold to 0.
REQ-029 SHALL, on reset mid-line, discard the partial line; the next accepted pixel is column 0 of a new line.

Structure
REQ-030 SHALL place pixel_t, the state enum and the luma function in the shared package pixel_pkg.
REQ-031 SHALL implement the 3-tap median as the sub-module median3, which is combinational with 8-bit inputs.

Verification
REQ-032 SHALL cover a flat line: 4 pixels (100,100,100) with threshold 10 -> 4 outputs with magnitude 0 and edge 0, out_last on index 3, and edge_count 0.
REQ-033 SHALL cover a step line: gray 0,0,0,200,200,200 with threshold 50 -> only index 3 has magnitude 200 and edge 1, and edge_count becomes 1.
REQ-034 SHALL cover impulse noise: gray 0,0,255,0,0 with threshold 10 -> every magnitude is 0, there are no edges, and edge_count is 0.
REQ-035 SHALL cover backpressure: the step line with out_ready low for 5 cycles mid-line -> in_ready low, outputs stable, and the 6 outputs identical to the unstalled run.
REQ-036 SHALL cover a single-pixel line (10,20,30) with in_last -> one output with index 0, magnitude 0 and last 1, and no RUN state visited.
REQ-037 SHALL cover reset asserted after 3 pixels of a line -> out_valid 0 immediately, and the following line reports starting from index 0.
